predictor_update_scheduler: RTL and testbench

Sits between the instruction fetcher, the commit stage and the single-ported 2-level branch predictor. It multiplexes the predictor's one port (predict_en has priority over feedback_en) between fetch-time prediction requests and committed-branch feedback. Feedback is buffered in a small FIFO and drained in idle predict cycles. A starvation guard forces a drain when feedback has been blocked for too long.

---
 rtl/predictor_pkg.sv | 17 +
 rtl/predictor_fb_fifo.sv | 47 ++++
 rtl/predictor_update_scheduler.sv | 142 ++++++++++++++
 tb/tb_predictor_update_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/predictor_pkg.sv
// rtl/predictor_pkg.sv - shared width, scheduler state encoding and feedback entry type
package predictor_pkg;

   localparam int ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FORCE = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic                  taken;
   } fb_entry_t;

endpackage

// File: rtl/predictor_fb_fifo.sv
// rtl/predictor_fb_fifo.sv - synchronous feedback FIFO with push/pop, occupancy count and head
module predictor_fb_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Storage is not reset; only pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
         end
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/predictor_update_scheduler.sv
// rtl/predictor_update_scheduler.sv - shares the predictor port between fetch predictions and queued commit feedback
// Optional statistics counters are enabled by defining PREDICTOR_SCHED_STATS_EN.
module predictor_update_scheduler #(
   parameter int ADDR_WIDTH   = predictor_pkg::ADDR_WIDTH,
   parameter int FB_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  Sys_clk,
   input  logic                  Sys_rst,
   input  logic                  Sys_rdy,
   input  logic                  IF_predict_req,
   input  logic [ADDR_WIDTH-1:0] IF_pc,
   output logic                  SCHIF_predict_valid,
   output logic                  SCHIF_predict_result,
   input  logic                  ROB_fb_valid,
   input  logic [ADDR_WIDTH-1:0] ROB_fb_pc,
   input  logic                  ROB_fb_taken,
   output logic                  SCHROB_fb_ready,
   output logic                  SCHPD_predict_en,
   output logic [ADDR_WIDTH-1:0] SCHPD_pc,
   output logic                  SCHPD_feedback_en,
   output logic                  SCHPD_branch_result,
   output logic [ADDR_WIDTH-1:0] SCHPD_feedback_pc,
   input  logic                  PDSCH_predict_result
`ifdef PREDICTOR_SCHED_STATS_EN
   ,
   output logic [31:0]           SCH_stat_predicts,
   output logic [31:0]           SCH_stat_updates,
   output logic [31:0]           SCH_stat_forced
`endif
);
   import predictor_pkg::*;

   localparam int CNT_W = $clog2(FB_DEPTH) + 1;
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FB_DEPTH);

   sched_state_e     state_q, state_d;
   logic [SC_W-1:0]  starve_q, starve_d;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_after_pop;
   logic [ADDR_WIDTH:0] head;
   logic push, pop, grant;

   assign SCHROB_fb_ready = (count < FULL_CNT);
   assign push            = Sys_rdy & ROB_fb_valid & SCHROB_fb_ready;
   assign count_after_pop = count - CNT_W'(1) + CNT_W'(push);

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      grant    = 1'b0;
      pop      = 1'b0;
      if (Sys_rdy) begin
         case (state_q)
            ST_IDLE: begin
               grant = IF_predict_req;
               if (push) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (IF_predict_req) begin
                  grant = 1'b1;
                  if (starve_q != STARVE_MAX) starve_d = starve_q + SC_W'(1);
                  if (starve_d == STARVE_MAX) state_d = ST_FORCE;
               end else begin
                  pop      = 1'b1;
                  starve_d = '0;
                  state_d  = (count_after_pop == '0) ? ST_IDLE : ST_DRAIN;
               end
            end
            ST_FORCE: begin
               // The fetcher sees no grant this cycle and retries.
               pop      = 1'b1;
               starve_d = '0;
               state_d  = (count_after_pop == '0) ? ST_IDLE : ST_DRAIN;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Sys_clk) begin
      if (Sys_rst) begin
         state_q  <= ST_IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   predictor_fb_fifo #(
      .WIDTH (ADDR_WIDTH + 1),
      .DEPTH (FB_DEPTH)
   ) u_fb_fifo (
      .clk       (Sys_clk),
      .rst       (Sys_rst),
      .push      (push),
      .pop       (pop),
      .push_data ({ROB_fb_pc, ROB_fb_taken}),
      .head      (head),
      .count     (count)
   );

   assign SCHPD_predict_en     = grant;
   assign SCHIF_predict_valid  = grant;
   assign SCHIF_predict_result = grant & PDSCH_predict_result;
   assign SCHPD_pc             = IF_pc;
   assign SCHPD_feedback_en    = pop;
   assign SCHPD_feedback_pc    = head[ADDR_WIDTH:1];
   assign SCHPD_branch_result  = head[0];

`ifdef PREDICTOR_SCHED_STATS_EN
   logic [31:0] stat_predicts_q, stat_predicts_d;
   logic [31:0] stat_updates_q, stat_updates_d;
   logic [31:0] stat_forced_q, stat_forced_d;

   always_comb begin
      stat_predicts_d = stat_predicts_q + 32'(grant);
      stat_updates_d  = stat_updates_q + 32'(pop);
      stat_forced_d   = stat_forced_q + 32'(pop && (state_q == ST_FORCE));
   end

   always_ff @(posedge Sys_clk) begin
      if (Sys_rst) begin
         stat_predicts_q <= '0;
         stat_updates_q  <= '0;
         stat_forced_q   <= '0;
      end else begin
         stat_predicts_q <= stat_predicts_d;
         stat_updates_q  <= stat_updates_d;
         stat_forced_q   <= stat_forced_d;
      end
   end

   assign SCH_stat_predicts = stat_predicts_q;
   assign SCH_stat_updates  = stat_updates_q;
   assign SCH_stat_forced   = stat_forced_q;
`endif

endmodule

// File: tb/tb_predictor_update_scheduler.sv
// tb/tb_predictor_update_scheduler.sv - self-checking bench for predictor_update_scheduler
module tb_predictor_update_scheduler;
   import predictor_pkg::*;

   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int LIM   = 8;

   logic          clk = 1'b0;
   logic          rst, rdy, req, pdr, fbv, tk;
   logic [AW-1:0] ifpc, fbpc;
   logic          pv, pres, ready, pen, fen, fres;
   logic [AW-1:0] pdpc, fpc;

   always #5 clk = ~clk;

   predictor_update_scheduler #(
      .ADDR_WIDTH   (AW),
      .FB_DEPTH     (DEPTH),
      .STARVE_LIMIT (LIM)
   ) dut (
      .Sys_clk              (clk),
      .Sys_rst              (rst),
      .Sys_rdy              (rdy),
      .IF_predict_req       (req),
      .IF_pc                (ifpc),
      .SCHIF_predict_valid  (pv),
      .SCHIF_predict_result (pres),
      .ROB_fb_valid         (fbv),
      .ROB_fb_pc            (fbpc),
      .ROB_fb_taken         (tk),
      .SCHROB_fb_ready      (ready),
      .SCHPD_predict_en     (pen),
      .SCHPD_pc             (pdpc),
      .SCHPD_feedback_en    (fen),
      .SCHPD_branch_result  (fres),
      .SCHPD_feedback_pc    (fpc),
      .PDSCH_predict_result (pdr)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queued commits in order, blocked-cycle count, pending forced drain.
   fb_entry_t mq[$];
   int        m_starve;
   bit        m_force;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle(input bit r, input bit y, input bit q, input bit p, input bit v,
                        input logic [AW-1:0] ip, input logic [AW-1:0] fp, input bit t,
                        output bit o_pv, output bit o_pres, output bit o_fen,
                        output logic [AW-1:0] o_fpc, output bit o_fres, output bit o_ready,
                        output logic [AW-1:0] o_pdpc);
      bit e_grant, e_pop, e_ready;
      int sz;
      rst = r; rdy = y; req = q; pdr = p; fbv = v; ifpc = ip; fbpc = fp; tk = t;
      @(negedge clk);
      sz      = mq.size();
      e_ready = (sz < DEPTH);
      e_grant = 1'b0;
      e_pop   = 1'b0;
      if (y) begin
         if (m_force) e_pop = 1'b1;
         else if (q) e_grant = 1'b1;
         else if (sz > 0) e_pop = 1'b1;
      end
      chk("fb_ready", ready, e_ready);
      chk("predict_valid", pv, e_grant);
      chk("predict_en", pen, e_grant);
      chk("feedback_en", fen, e_pop);
      if (e_grant) begin
         chk("predict_result", pres, p);
         chk("predict_pc", pdpc, ip);
      end
      if (e_pop) begin
         chk("feedback_pc", fpc, mq[0].pc);
         chk("branch_result", fres, mq[0].taken);
      end
      o_pv = pv; o_pres = pres; o_fen = fen; o_fpc = fpc; o_fres = fres;
      o_ready = ready; o_pdpc = pdpc;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_starve = 0;
         m_force  = 0;
      end else if (y) begin
         if (e_pop) begin
            void'(mq.pop_front());
            m_starve = 0;
            m_force  = 0;
         end else if (e_grant && sz > 0) begin
            if (m_starve < LIM) m_starve++;
            if (m_starve == LIM) m_force = 1;
         end
         if (v && sz < DEPTH) mq.push_back('{pc: fp, taken: t});
      end
      #1;
   endtask

   typedef struct {
      bit            rst, rdy, req, pdr, fbv;
      logic [AW-1:0] fpc;
      bit            tk;
      bit            e_pv, e_pres, e_fen;
      logic [AW-1:0] e_fpc;
      bit            e_ftk, e_rdy;
   } vec_t;

   vec_t vecs[14];

   initial begin
      bit            a_pv, a_pres, a_fen, a_fres, a_ready;
      logic [AW-1:0] a_fpc, a_pdpc;
      int            fen_cyc[$];
      logic [AW-1:0] fen_pc[$];
      int            first_fen;

      vecs[0]  = '{0,1,1,1,0, 32'h0,    0, 1,1,0, 32'h0,    0,1};
      vecs[1]  = '{0,1,0,0,1, 32'h1000, 1, 0,0,0, 32'h0,    0,1};
      vecs[2]  = '{0,1,0,0,0, 32'h0,    0, 0,0,1, 32'h1000, 1,1};
      vecs[3]  = '{0,1,0,0,0, 32'h0,    0, 0,0,0, 32'h0,    0,1};
      vecs[4]  = '{0,1,1,0,1, 32'h2000, 0, 1,0,0, 32'h0,    0,1};
      vecs[5]  = '{0,1,0,0,1, 32'h3000, 1, 0,0,1, 32'h2000, 0,1};
      vecs[6]  = '{0,1,0,0,1, 32'h4000, 0, 0,0,1, 32'h3000, 1,1};
      vecs[7]  = '{0,1,0,0,1, 32'h5000, 1, 0,0,1, 32'h4000, 0,1};
      vecs[8]  = '{0,1,0,0,1, 32'h6000, 1, 0,0,1, 32'h5000, 1,1};
      vecs[9]  = '{0,1,1,1,1, 32'h7000, 0, 1,1,0, 32'h0,    0,1};
      vecs[10] = '{0,1,1,0,1, 32'h8000, 1, 1,0,0, 32'h0,    0,1};
      vecs[11] = '{1,1,0,0,0, 32'h0,    0, 0,0,1, 32'h6000, 1,1};
      vecs[12] = '{0,1,0,0,0, 32'h0,    0, 0,0,0, 32'h0,    0,1};
      vecs[13] = '{0,1,1,0,0, 32'h0,    0, 1,0,0, 32'h0,    0,1};

      rst = 1; rdy = 1; req = 0; pdr = 0; fbv = 0; tk = 0; ifpc = '0; fbpc = '0;
      @(posedge clk); #1;
      mq.delete(); m_starve = 0; m_force = 0;

      for (int i = 0; i < 14; i++) begin
         cycle(vecs[i].rst, vecs[i].rdy, vecs[i].req, vecs[i].pdr, vecs[i].fbv,
               32'hA000_0000 + AW'(i), vecs[i].fpc, vecs[i].tk,
               a_pv, a_pres, a_fen, a_fpc, a_fres, a_ready, a_pdpc);
         chk($sformatf("vec%0d_pv", i), a_pv, vecs[i].e_pv);
         chk($sformatf("vec%0d_fen", i), a_fen, vecs[i].e_fen);
         chk($sformatf("vec%0d_rdy", i), a_ready, vecs[i].e_rdy);
         if (vecs[i].e_pv) begin
            chk($sformatf("vec%0d_pres", i), a_pres, vecs[i].e_pres);
            chk($sformatf("vec%0d_pdpc", i), a_pdpc, 32'hA000_0000 + AW'(i));
         end
         if (vecs[i].e_fen) begin
            chk($sformatf("vec%0d_fpc", i), a_fpc, vecs[i].e_fpc);
            chk($sformatf("vec%0d_ftk", i), a_fres, vecs[i].e_ftk);
         end
      end

      // Continuous predicts with a full queue: forced drains every LIM+1 cycles.
      for (int c = 0; c < 45; c++) begin
         cycle(0, 1, 1, c[0], (c < 4) || (c == 9), 32'hB000_0000 + AW'(c),
               32'hF000_0000 + AW'(c * 16), c[1],
               a_pv, a_pres, a_fen, a_fpc, a_fres, a_ready, a_pdpc);
         if (c == 4 || c == 9) chk($sformatf("full_ready_c%0d", c), a_ready, 1'b0);
         if (a_fen) begin
            fen_cyc.push_back(c);
            fen_pc.push_back(a_fpc);
         end
      end
      chk("force_count", fen_cyc.size(), 4);
      for (int k = 0; k < 4 && k < fen_cyc.size(); k++) begin
         chk($sformatf("force_cycle%0d", k), fen_cyc[k], 9 + 9 * k);
         chk($sformatf("force_pc%0d", k), fen_pc[k], 32'hF000_0000 + AW'(k * 16));
      end

      // A Sys_rdy gap must not advance the starvation count.
      first_fen = -1;
      for (int c = 0; c < 16; c++) begin
         cycle(0, !(c >= 4 && c <= 8), 1, 1, c < 2, 32'hC000_0000 + AW'(c),
               32'hD000_0000 + AW'(c), 1,
               a_pv, a_pres, a_fen, a_fpc, a_fres, a_ready, a_pdpc);
         if (a_fen && first_fen < 0) first_fen = c;
      end
      chk("gap_first_force", first_fen, 14);
      for (int c = 0; c < 3; c++)
         cycle(0, 1, 0, 0, 0, '0, '0, 0,
               a_pv, a_pres, a_fen, a_fpc, a_fres, a_ready, a_pdpc);

      for (int c = 0; c < 3000; c++) begin
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
               $urandom_range(0, 9) < 6, 1'($urandom), 1'($urandom),
               $urandom, $urandom, 1'($urandom),
               a_pv, a_pres, a_fen, a_fpc, a_fres, a_ready, a_pdpc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
